regbank_sequencer: RTL and testbench

//  Front-end sequencer for the single-port RegisterBank (one regNum/dataIn/dataOut port).

---
 rtl/regbank_sequencer_pkg.sv | 17 +
 rtl/regbank_sequencer.sv | 136 +++++++++++++
 tb/tb_regbank_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_sequencer_pkg.sv
// Shared types and defaults for the register-bank sequencer.
// Widths and FSM state encodings used by the sequencer and its users.
package regbank_sequencer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ1 = 3'd2,
        READ2 = 3'd3,
        FETCH = 3'd4,
        DONE  = 3'd5
    } seqState_t;

endpackage

// File: rtl/regbank_sequencer.sv
// Serialises writeback + two source reads onto a single-port register bank
// and returns both operands on a valid/ready handshake.
module regbank_sequencer
    import regbank_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  wbEnable,
    input  logic [DATA_WIDTH-1:0] wbData,
    output logic                  opValid,
    input  logic                  opReady,
    output logic [DATA_WIDTH-1:0] op1,
    output logic [DATA_WIDTH-1:0] op2,
    output logic [ADDR_WIDTH-1:0] bankRegNum,
    output logic [DATA_WIDTH-1:0] bankDataIn,
    output logic                  bankWriteEnable,
    input  logic [DATA_WIDTH-1:0] bankDataOut
);

    seqState_t state, stateNext;

    logic [ADDR_WIDTH-1:0] rs1Q, rs2Q, rdQ;
    logic [ADDR_WIDTH-1:0] rs1Next, rs2Next, rdNext;
    logic                  wbEnQ, wbEnNext;
    logic [DATA_WIDTH-1:0] wbDataQ, wbDataNext;

    logic                  opValidNext;
    logic [DATA_WIDTH-1:0] op1Next, op2Next;
    logic [ADDR_WIDTH-1:0] regNumNext;
    logic [DATA_WIDTH-1:0] dataInNext;
    logic                  weNext;
    logic                  accept;

    // Held low during reset even though state already reads IDLE.
    assign reqReady = reset & ((state == IDLE) |
                               ((state == DONE) & opReady));
    assign accept   = reqValid & reqReady;

    always_comb begin
        stateNext   = state;
        rs1Next     = rs1Q;
        rs2Next     = rs2Q;
        rdNext      = rdQ;
        wbEnNext    = wbEnQ;
        wbDataNext  = wbDataQ;
        opValidNext = opValid;
        op1Next     = op1;
        op2Next     = op2;
        regNumNext  = bankRegNum;
        dataInNext  = bankDataIn;
        weNext      = 1'b0;

        if (accept) begin
            rs1Next    = rs1;
            rs2Next    = rs2;
            rdNext     = rd;
            wbEnNext   = wbEnable;
            wbDataNext = wbData;
        end

        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    stateNext   = (wbEnNext && rdNext != '0) ? WRITE : READ1;
                    opValidNext = 1'b0;
                end else if (state == DONE && opReady) begin
                    stateNext   = IDLE;
                    opValidNext = 1'b0;
                end
            end
            WRITE: stateNext = READ1;
            READ1: stateNext = READ2;
            READ2: begin
                // Bank data seen here was addressed during READ1.
                op1Next   = (rs1Q == '0) ? '0 : bankDataOut;
                stateNext = FETCH;
            end
            FETCH: begin
                op2Next     = (rs2Q == '0) ? '0 : bankDataOut;
                opValidNext = 1'b1;
                stateNext   = DONE;
            end
        endcase

        // Bank port is registered, so it is set up for the state being entered.
        unique case (stateNext)
            WRITE: begin
                regNumNext = rdNext;
                dataInNext = wbDataNext;
                weNext     = 1'b1;
            end
            READ1:   regNumNext = rs1Next;
            READ2:   regNumNext = rs2Next;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            rs1Q            <= '0;
            rs2Q            <= '0;
            rdQ             <= '0;
            wbEnQ           <= 1'b0;
            wbDataQ         <= '0;
            opValid         <= 1'b0;
            op1             <= '0;
            op2             <= '0;
            bankRegNum      <= '0;
            bankDataIn      <= '0;
            bankWriteEnable <= 1'b0;
        end else begin
            state           <= stateNext;
            rs1Q            <= rs1Next;
            rs2Q            <= rs2Next;
            rdQ             <= rdNext;
            wbEnQ           <= wbEnNext;
            wbDataQ         <= wbDataNext;
            opValid         <= opValidNext;
            op1             <= op1Next;
            op2             <= op2Next;
            bankRegNum      <= regNumNext;
            bankDataIn      <= dataInNext;
            bankWriteEnable <= weNext;
        end
    end

endmodule

// File: tb/tb_regbank_sequencer.sv
// Self-checking bench: sequencer driving a behavioural single-port register bank.
// Vector table, hand-written corner sequences and a randomised model comparison.
module tb_regbank_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [3:0]  rs1, rs2, rd;
    logic        wbEnable;
    logic [31:0] wbData;
    logic        opValid;
    logic        opReady;
    logic [31:0] op1, op2;
    logic [3:0]  bankRegNum;
    logic [31:0] bankDataIn;
    logic        bankWriteEnable;
    logic [31:0] bankDataOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    logic [31:0] refRegs [16];
    int          writeCount = 0;

    always #5 clk = ~clk;

    regbank_sequencer dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .wbEnable(wbEnable), .wbData(wbData),
        .opValid(opValid), .opReady(opReady),
        .op1(op1), .op2(op2),
        .bankRegNum(bankRegNum), .bankDataIn(bankDataIn),
        .bankWriteEnable(bankWriteEnable), .bankDataOut(bankDataOut)
    );

    // Single-port bank: synchronous write, registered read.
    always @(posedge clk) begin
        if (bankWriteEnable) begin
            mem[bankRegNum] <= bankDataIn;
            writeCount      <= writeCount + 1;
        end
        bankDataOut <= mem[bankRegNum];
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic waitOp(output int lat);
        lat = 0;
        while (!opValid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runReq(input logic [3:0] a1, input logic [3:0] a2,
                          input logic [3:0] d, input logic we,
                          input logic [31:0] wd, input logic [31:0] e1,
                          input logic [31:0] e2, input int eLat,
                          input int eWr, input string nm);
        int n, lat, w0;
        @(negedge clk);
        reqValid = 1'b1;
        rs1 = a1; rs2 = a2; rd = d;
        wbEnable = we; wbData = wd;
        opReady = 1'b0;
        #1;
        n = 0;
        while (!reqReady && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!reqReady) begin
            check({nm, " reqReady"}, 0, 1);
            reqValid = 1'b0;
            return;
        end
        w0 = writeCount;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        waitOp(lat);
        check({nm, " latency"}, lat, eLat);
        check({nm, " op1"}, op1, e1);
        check({nm, " op2"}, op2, e2);
        check({nm, " writes"}, writeCount - w0, eWr);
        if (we && d != 0) refRegs[d] = wd;
        opReady = 1'b1;
        @(negedge clk);
        opReady = 1'b0;
        check({nm, " drain"}, opValid, 0);
    endtask

    typedef struct {
        logic [3:0]  a1, a2, d;
        logic        we;
        logic [31:0] wd, e1, e2;
        int          lat, wr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        logic [31:0] snap [16];
        logic [31:0] tmp [16];
        logic [31:0] s1, s2;
        logic same;

        vecs[0] = '{4'd0, 4'd0, 4'd3, 1'b1, 32'h12345678, 32'h0, 32'h0, 4, 1};
        vecs[1] = '{4'd3, 4'd0, 4'd7, 1'b1, 32'hFFFFFFFF,
                    32'h12345678, 32'h0, 4, 1};
        vecs[2] = '{4'd3, 4'd7, 4'd0, 1'b0, 32'h0,
                    32'h12345678, 32'hFFFFFFFF, 3, 0};
        vecs[3] = '{4'd5, 4'd0, 4'd5, 1'b1, 32'hDEADBEEF,
                    32'hDEADBEEF, 32'h0, 4, 1};
        vecs[4] = '{4'd5, 4'd3, 4'd0, 1'b1, 32'hF0F0F0F0,
                    32'hDEADBEEF, 32'h12345678, 3, 0};
        vecs[5] = '{4'd7, 4'd7, 4'd7, 1'b1, 32'hA5A5A5A5,
                    32'hA5A5A5A5, 32'hA5A5A5A5, 4, 1};
        vecs[6] = '{4'd0, 4'd5, 4'd9, 1'b0, 32'h11111111,
                    32'h0, 32'hDEADBEEF, 3, 0};

        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h0;
            refRegs[i] = 32'h0;
        end

        reset = 1'b0;
        reqValid = 1'b0; opReady = 1'b0;
        rs1 = 0; rs2 = 0; rd = 0; wbEnable = 0; wbData = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst reqReady", reqReady, 0);
        check("rst opValid", opValid, 0);
        check("rst bankWE", bankWriteEnable, 0);
        check("rst regNum", bankRegNum, 0);
        check("rst op1", op1, 0);
        reset = 1'b1;
        #1;
        check("rel reqReady", reqReady, 1);

        for (int i = 0; i < 7; i++) begin
            for (int r = 0; r < 16; r++) snap[r] = mem[r];
            runReq(vecs[i].a1, vecs[i].a2, vecs[i].d, vecs[i].we,
                   vecs[i].wd, vecs[i].e1, vecs[i].e2,
                   vecs[i].lat, vecs[i].wr, $sformatf("vec%0d", i));
            if (vecs[i].d == 0) begin
                same = 1'b1;
                for (int r = 1; r < 16; r++)
                    if (mem[r] !== snap[r]) same = 1'b0;
                check($sformatf("vec%0d regs kept", i), same, 1);
            end
        end

        // Backpressure then back-to-back accept.
        @(negedge clk);
        reqValid = 1'b1; rs1 = 3; rs2 = 5; rd = 0; wbEnable = 0;
        @(posedge clk);
        @(negedge clk);
        rs1 = 5; rs2 = 3; rd = 2; wbEnable = 1; wbData = 32'h0BADF00D;
        waitOp(lat);
        check("bp latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp reqReady", reqReady, 0);
            check("bp opValid", opValid, 1);
            check("bp op1", op1, 32'h12345678);
            check("bp op2", op2, 32'hDEADBEEF);
            @(negedge clk);
        end
        opReady = 1'b1;
        #1;
        check("b2b reqReady", reqReady, 1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0; opReady = 1'b0;
        check("b2b opValid low", opValid, 0);
        waitOp(lat);
        check("b2b latency", lat, 4);
        check("b2b op1", op1, 32'hDEADBEEF);
        check("b2b op2", op2, 32'h12345678);
        refRegs[2] = 32'h0BADF00D;
        opReady = 1'b1;
        @(negedge clk);
        opReady = 1'b0;

        // Reset asserted while in READ2.
        reqValid = 1'b1; rs1 = 2; rs2 = 7; rd = 0; wbEnable = 0;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst opValid", opValid, 0);
        check("midrst regNum", bankRegNum, 0);
        check("midrst dataIn", bankDataIn, 0);
        check("midrst bankWE", bankWriteEnable, 0);
        check("midrst op1", op1, 0);
        check("midrst reqReady", reqReady, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("postrst reqReady", reqReady, 1);
        runReq(4'd2, 4'd7, 4'd0, 1'b0, 32'h0,
               32'h0BADF00D, 32'hA5A5A5A5, 3, 0, "postrst");

        // Clear, then sweep all registers.
        for (int i = 1; i < 16; i++)
            runReq(4'(i), 4'd0, 4'(i), 1'b1, 32'h0,
                   32'h0, 32'h0, 4, 1, "clear");
        for (int i = 1; i < 16; i++)
            runReq(4'(i), 4'((i % 15) + 1), 4'(i), 1'b1, 32'hFFFFFFFF,
                   32'hFFFFFFFF, (i == 15) ? 32'hFFFFFFFF : 32'h0,
                   4, 1, $sformatf("sweep%0d", i));

        // Randomised traffic against the register-file model.
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  a1, a2, d;
            logic        we;
            logic [31:0] wd;
            a1 = 4'($urandom_range(0, 15));
            a2 = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            for (int r = 0; r < 16; r++) tmp[r] = refRegs[r];
            if (we && d != 0) tmp[d] = wd;
            s1 = (a1 == 0) ? 32'h0 : tmp[a1];
            s2 = (a2 == 0) ? 32'h0 : tmp[a2];
            runReq(a1, a2, d, we, wd, s1, s2,
                   (we && d != 0) ? 4 : 3, (we && d != 0) ? 1 : 0,
                   $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
